// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial subtractor state encoding,
// default operand width and the bit-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must be able to hold the value width, hence width+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (in1 - in2 - bin), LSB first, one bit per
// clock through a single full_sub cell, with a start/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_t       state, state_next;
  logic [WIDTH-1:0] a, b, r;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bo;
  logic             accept, last;

  full_sub u_cell (
    .a  (a[0]),
    .b  (b[0]),
    .bi (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Operands are only taken when idle or in the single done cycle.
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // NOTE: every output of a combinational block gets a default first;
  // a path that leaves state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a    <= '0;
      b    <= '0;
      r    <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      a   <= in1;
      b   <= in2;
      br  <= bin;
      r   <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      a   <= a >> 1;
      b   <= b >> 1;
      br  <= cell_bo;
      r   <= {cell_d, r[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      // The final bit is still in flight, so publish the shifted-in value.
      if (last) begin
        diff <= {cell_d, r[WIDTH-1:1]};
        bout <= cell_bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, exhaustive
// operand sweep, busy-time start, back-to-back and mid-operation reset.
module tb_serial_subtractor;
  import arith_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst, start, bin;
  logic [WIDTH-1:0] in1, in2;
  logic             busy, done, bout;
  logic [WIDTH-1:0] diff;

  int checks = 0;
  int errors = 0;

  // Last result the outputs are expected to hold.
  logic [WIDTH-1:0] exp_diff;
  logic             exp_bout;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction; borrow is a negative result.
  function automatic logic [WIDTH:0] ref_sub(input int x, input int y, input int c);
    int v;
    logic [WIDTH:0] res;
    v = x - y - c;
    res[WIDTH]     = (v < 0);
    res[WIDTH-1:0] = WIDTH'(v & MASK);
    return res;
  endfunction

  function automatic int adder(input int x, input int y, input int c);
    return (x + y + c) & MASK;
  endfunction

  // One operation; optionally pulses start with other operands mid-busy.
  task automatic run_op(input int x, input int y, input int c, input bit poke, input string tag);
    logic [WIDTH:0] r;
    int cyc;
    @(negedge clk);
    check({tag, "/idle_done"}, done, 0);
    in1 = WIDTH'(x); in2 = WIDTH'(y); bin = c[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1 = WIDTH'($urandom); in2 = WIDTH'($urandom); bin = 1'($urandom);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3 * WIDTH) begin
      check({tag, "/busy"}, busy, 1);
      check({tag, "/hold_diff"}, diff, exp_diff);
      check({tag, "/hold_bout"}, bout, exp_bout);
      if (poke) start = (cyc == 1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "/latency"}, cyc, WIDTH);
    r = ref_sub(x, y, c);
    check({tag, "/diff"}, diff, r[WIDTH-1:0]);
    check({tag, "/bout"}, bout, r[WIDTH]);
    check({tag, "/busy_at_done"}, busy, 0);
    check({tag, "/roundtrip"}, adder(int'(diff), y, c), x);
    exp_diff = r[WIDTH-1:0];
    exp_bout = r[WIDTH];
  endtask

  initial begin
    logic [WIDTH:0] ra, rb;
    int cyc, gap;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
    exp_diff = '0; exp_bout = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/diff", diff, 0);
    check("rst/bout", bout, 0);
    rst = 1'b0;

    // Directed cases.
    run_op(0, 0, 0, 0, "z_z_0");
    run_op(0, 0, 1, 0, "z_z_1");
    run_op(7, 8, 0, 0, "7_8_0");
    run_op(15, 15, 1, 0, "15_15_1");
    run_op(2, 5, 1, 0, "2_5_1");
    run_op(13, 6, 1, 0, "13_6_1");

    // Start during busy is ignored; random operands are on the bus then.
    run_op(11, 4, 0, 1, "poke");
    @(negedge clk);
    check("poke/no_requeue", busy, 0);

    // Back-to-back: start held through the done cycle.
    for (int t = 0; t < 4; t++) begin
      int xa, ya, ca, xb, yb, cb;
      xa = $urandom_range(MASK); ya = $urandom_range(MASK); ca = $urandom_range(1);
      xb = $urandom_range(MASK); yb = $urandom_range(MASK); cb = $urandom_range(1);
      @(negedge clk);
      in1 = WIDTH'(xa); in2 = WIDTH'(ya); bin = ca[0]; start = 1'b1;
      @(negedge clk);
      in1 = WIDTH'(xb); in2 = WIDTH'(yb); bin = cb[0];
      cyc = 0;
      while (done !== 1'b1 && cyc < 3 * WIDTH) begin
        @(negedge clk);
        cyc++;
      end
      ra = ref_sub(xa, ya, ca);
      check("b2b/first_diff", diff, ra[WIDTH-1:0]);
      check("b2b/first_bout", bout, ra[WIDTH]);
      gap = 0;
      @(negedge clk);
      gap++;
      start = 1'b0;
      while (done !== 1'b1 && gap < 3 * WIDTH) begin
        @(negedge clk);
        gap++;
      end
      check("b2b/gap", gap, WIDTH + 1);
      rb = ref_sub(xb, yb, cb);
      check("b2b/second_diff", diff, rb[WIDTH-1:0]);
      check("b2b/second_bout", bout, rb[WIDTH]);
      exp_diff = rb[WIDTH-1:0];
      exp_bout = rb[WIDTH];
    end

    // Reset after two SHIFT cycles of 9-3-0, then rst together with start.
    @(negedge clk);
    in1 = 4'd9; in2 = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort/busy", busy, 0);
    check("abort/done", done, 0);
    check("abort/diff", diff, 0);
    check("abort/bout", bout, 0);
    exp_diff = '0; exp_bout = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("rst_start/busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      check("abort/no_done", done, 0);
    end
    run_op(9, 3, 0, 0, "after_abort");

    // Exhaustive sweep of every (in1, in2, bin).
    for (int x = 0; x <= MASK; x++)
      for (int y = 0; y <= MASK; y++)
        for (int c = 0; c < 2; c++)
          run_op(x, y, c, 0, "sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
